// File: rtl/turbo_codec_scheduler_if.sv
// ---------------------------------------------------------------------------
// turbo_codec_scheduler_if : request, core-pin and response bundle for the scheduler
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface turbo_codec_scheduler_if #(
  parameter int BLOCK_BITS = 8
);
  logic                  enc_valid;
  logic [BLOCK_BITS-1:0] enc_data;
  logic                  enc_ready;
  logic                  dec_valid;
  logic [2:0]            dec_sym;
  logic                  dec_ready;
  logic                  cdc_mode;
  logic                  cdc_start;
  logic                  cdc_bit;
  logic [2:0]            cdc_sym;
  logic                  cdc_valid;
  logic [2:0]            cdc_enc_out;
  logic                  cdc_dec_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_is_enc;
  logic [2:0]            rsp_data;
  logic                  rsp_timeout;
  logic                  busy;

  modport master (
    input  enc_valid, enc_data, dec_valid, dec_sym,
    input  cdc_valid, cdc_enc_out, cdc_dec_out, rsp_ready,
    output enc_ready, dec_ready, cdc_mode, cdc_start, cdc_bit, cdc_sym,
    output rsp_valid, rsp_is_enc, rsp_data, rsp_timeout, busy
  );

  modport slave (
    output enc_valid, enc_data, dec_valid, dec_sym,
    output cdc_valid, cdc_enc_out, cdc_dec_out, rsp_ready,
    input  enc_ready, dec_ready, cdc_mode, cdc_start, cdc_bit, cdc_sym,
    input  rsp_valid, rsp_is_enc, rsp_data, rsp_timeout, busy
  );
endinterface

`default_nettype wire

// File: rtl/turbo_codec_scheduler.sv
// ---------------------------------------------------------------------------
// turbo_codec_scheduler : round-robin sharing of one turbo core between encode/decode clients
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module turbo_codec_scheduler #(
  parameter int BLOCK_BITS = 8,
  parameter int TIMEOUT    = 31,
  parameter int TO_W       = 5
) (
  input  wire logic                clk,
  input  wire logic                reset,
  turbo_codec_scheduler_if.master  bus_io
);

  localparam int   IDX_W  = (BLOCK_BITS > 1) ? $clog2(BLOCK_BITS) : 1;
  localparam logic RR_ENC = 1'b1;
  localparam logic RR_DEC = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENC_LOAD  = 3'd1,
    S_DEC_ISSUE = 3'd2,
    S_WAIT      = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t                state_q;
  logic                  rr_last_q;
  logic [BLOCK_BITS-1:0] data_q;
  logic [IDX_W-1:0]      idx_q;
  logic [TO_W-1:0]       wd_q;
  logic                  mode_q;
  logic                  start_q;
  logic                  bit_q;
  logic [2:0]            sym_q;
  logic                  rsp_valid_q;
  logic                  rsp_is_enc_q;
  logic [2:0]            rsp_data_q;
  logic                  rsp_timeout_q;
  logic                  busy_q;

  logic                  grant_enc;
  logic                  grant_dec;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_enc = 1'b0;
    grant_dec = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus_io.enc_valid && bus_io.dec_valid) begin
        grant_enc = (rr_last_q == RR_DEC);
        grant_dec = (rr_last_q == RR_ENC);
      end else begin
        grant_enc = bus_io.enc_valid;
        grant_dec = bus_io.dec_valid;
      end
    end
  end

  assign bus_io.enc_ready   = grant_enc;
  assign bus_io.dec_ready   = grant_dec;
  assign bus_io.cdc_mode    = mode_q;
  assign bus_io.cdc_start   = start_q;
  assign bus_io.cdc_bit     = bit_q;
  assign bus_io.cdc_sym     = sym_q;
  assign bus_io.rsp_valid   = rsp_valid_q;
  assign bus_io.rsp_is_enc  = rsp_is_enc_q;
  assign bus_io.rsp_data    = rsp_data_q;
  assign bus_io.rsp_timeout = rsp_timeout_q;
  assign bus_io.busy        = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_last_q     <= RR_DEC;
      data_q        <= '0;
      idx_q         <= '0;
      wd_q          <= '0;
      mode_q        <= 1'b0;
      start_q       <= 1'b0;
      bit_q         <= 1'b0;
      sym_q         <= 3'b000;
      rsp_valid_q   <= 1'b0;
      rsp_is_enc_q  <= 1'b0;
      rsp_data_q    <= 3'b000;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Issue-pin registers are loaded here so bit 0 is on the pins in the first load cycle.
          if (grant_enc) begin
            data_q    <= bus_io.enc_data;
            rr_last_q <= RR_ENC;
            mode_q    <= 1'b1;
            start_q   <= 1'b1;
            bit_q     <= bus_io.enc_data[0];
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_ENC_LOAD;
          end else if (grant_dec) begin
            rr_last_q <= RR_DEC;
            mode_q    <= 1'b0;
            start_q   <= 1'b1;
            sym_q     <= bus_io.dec_sym;
            busy_q    <= 1'b1;
            state_q   <= S_DEC_ISSUE;
          end
        end
        S_ENC_LOAD: begin
          start_q <= 1'b0;
          if (idx_q == IDX_W'(BLOCK_BITS - 1)) begin
            bit_q   <= 1'b0;
            wd_q    <= '0;
            state_q <= S_WAIT;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
            bit_q <= data_q[idx_q + IDX_W'(1)];
          end
        end
        S_DEC_ISSUE: begin
          start_q <= 1'b0;
          sym_q   <= 3'b000;
          wd_q    <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus_io.cdc_valid) begin
            rsp_valid_q   <= 1'b1;
            rsp_is_enc_q  <= mode_q;
            rsp_data_q    <= mode_q ? bus_io.cdc_enc_out : {2'b00, bus_io.cdc_dec_out};
            rsp_timeout_q <= 1'b0;
            state_q       <= S_RESP;
          end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
            rsp_valid_q   <= 1'b1;
            rsp_is_enc_q  <= mode_q;
            rsp_data_q    <= 3'b000;
            rsp_timeout_q <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            wd_q <= wd_q + TO_W'(1);
          end
        end
        S_RESP: begin
          if (bus_io.rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_is_enc_q  <= 1'b0;
            rsp_data_q    <= 3'b000;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_turbo_codec_scheduler.sv
// ---------------------------------------------------------------------------
// tb_turbo_codec_scheduler : vector table, corner sequences and random jobs against a job-level model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_turbo_codec_scheduler;
  localparam int BLOCK_BITS = 8;
  localparam int TIMEOUT    = 31;
  localparam int TO_W       = 5;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  bit   last_enc;

  turbo_codec_scheduler_if #(.BLOCK_BITS(BLOCK_BITS)) bus ();

  turbo_codec_scheduler #(
    .BLOCK_BITS(BLOCK_BITS),
    .TIMEOUT   (TIMEOUT),
    .TO_W      (TO_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_enc;
    logic [7:0] pay;
    logic [2:0] sym;
    int         delay;
    logic [2:0] core_enc;
    logic       core_dec;
    int         stall;
    logic [2:0] exp_data;
    logic       exp_to;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level reference: a response arrives only if the core answers within TIMEOUT wait cycles.
  function automatic logic [3:0] model_rsp(input bit k, input int delay, input logic [2:0] ce, input logic cd);
    if (delay >= TIMEOUT) return 4'b1000;
    return {1'b0, k ? ce : {2'b00, cd}};
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_mode"},  32'(bus.cdc_mode), 0);
    chk({tag, "_start"}, 32'(bus.cdc_start), 0);
    chk({tag, "_bit"},   32'(bus.cdc_bit), 0);
    chk({tag, "_sym"},   32'(bus.cdc_sym), 0);
    chk({tag, "_rsp"},   32'({bus.rsp_valid, bus.rsp_is_enc, bus.rsp_data, bus.rsp_timeout}), 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_job(input bit want_enc, input bit both, input logic [7:0] pay, input logic [2:0] sym,
                        input int delay, input logic [2:0] core_enc, input logic core_dec, input int stall,
                        input logic [2:0] exp_data, input logic exp_to, input bit noise);
    bit k;
    logic [5:0] held;
    k = both ? !last_enc : want_enc;
    bus.enc_valid = both | want_enc;
    bus.dec_valid = both | !want_enc;
    bus.enc_data  = pay;
    bus.dec_sym   = sym;
    #1;
    chk("grant_enc_ready", 32'(bus.enc_ready), 32'(k));
    chk("grant_dec_ready", 32'(bus.dec_ready), 32'(!k));
    @(negedge clk);
    last_enc      = k;
    bus.enc_valid = 1'b0;
    bus.dec_valid = 1'b0;
    bus.enc_data  = 8'($urandom);
    bus.dec_sym   = 3'($urandom);
    if (k) begin
      for (int i = 0; i < BLOCK_BITS; i++) begin
        chk("enc_bit",   32'(bus.cdc_bit), 32'((pay >> i) & 8'd1));
        chk("enc_start", 32'(bus.cdc_start), 32'(i == 0));
        chk("enc_mode",  32'(bus.cdc_mode), 1);
        bus.cdc_valid   = noise ? 1'($urandom) : 1'b0;
        bus.cdc_enc_out = 3'($urandom);
        @(negedge clk);
      end
    end else begin
      chk("dec_start", 32'(bus.cdc_start), 1);
      chk("dec_sym",   32'(bus.cdc_sym), 32'(sym));
      chk("dec_mode",  32'(bus.cdc_mode), 0);
      bus.cdc_valid   = noise ? 1'($urandom) : 1'b0;
      bus.cdc_dec_out = 1'($urandom);
      @(negedge clk);
    end
    bus.cdc_valid = 1'b0;
    for (int w = 0; w < TIMEOUT; w++) begin
      chk("wait_pins", 32'({bus.cdc_start, bus.cdc_bit, bus.cdc_sym}), 0);
      chk("wait_no_rsp", 32'(bus.rsp_valid), 0);
      chk("wait_mode", 32'(bus.cdc_mode), 32'(k));
      bus.cdc_valid   = (w == delay);
      bus.cdc_enc_out = core_enc;
      bus.cdc_dec_out = core_dec;
      @(negedge clk);
      bus.cdc_valid   = 1'b0;
      if (w == delay) break;
    end
    chk("rsp_valid",   32'(bus.rsp_valid), 1);
    chk("rsp_is_enc",  32'(bus.rsp_is_enc), 32'(k));
    chk("rsp_data",    32'(bus.rsp_data), 32'(exp_data));
    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_to));
    chk("rsp_busy",    32'(bus.busy), 1);
    held = {bus.rsp_valid, bus.rsp_is_enc, bus.rsp_data, bus.rsp_timeout};
    bus.enc_valid = (stall > 0);
    bus.dec_valid = (stall > 0);
    #1;
    for (int s = 0; s < stall; s++) begin
      chk("stall_rsp_stable", 32'({bus.rsp_valid, bus.rsp_is_enc, bus.rsp_data, bus.rsp_timeout}), 32'(held));
      chk("stall_readies",    32'({bus.enc_ready, bus.dec_ready}), 0);
      chk("stall_start",      32'(bus.cdc_start), 0);
      chk("stall_mode",       32'(bus.cdc_mode), 32'(k));
      bus.cdc_valid   = noise ? 1'($urandom) : 1'b0;
      bus.cdc_enc_out = 3'($urandom);
      @(negedge clk);
    end
    bus.cdc_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("handshake_readies", 32'({bus.enc_ready, bus.dec_ready}), 0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.enc_valid = 1'b0;
    bus.dec_valid = 1'b0;
    chk("post_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("post_busy",      32'(bus.busy), 0);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    last_enc      = 1'b0;
    reset         = 1'b1;
    bus.enc_valid = 1'b0;
    bus.enc_data  = 8'h00;
    bus.dec_valid = 1'b0;
    bus.dec_sym   = 3'b000;
    bus.cdc_valid = 1'b0;
    bus.cdc_enc_out = 3'b000;
    bus.cdc_dec_out = 1'b0;
    bus.rsp_ready = 1'b0;

    //                 enc   pay    sym    dly  core   cd   stall exp    to
    tbl[0] = '{1'b1, 8'hA5, 3'b000, 2,   3'b101, 1'b0, 0,  3'b101, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 3'b111, 0,   3'b000, 1'b1, 0,  3'b001, 1'b0};
    tbl[2] = '{1'b1, 8'h3C, 3'b000, 255, 3'b111, 1'b1, 0,  3'b000, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 3'b010, 30,  3'b111, 1'b0, 1,  3'b000, 1'b0};
    tbl[4] = '{1'b1, 8'hFF, 3'b000, 31,  3'b110, 1'b0, 2,  3'b000, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 3'b101, 5,   3'b000, 1'b1, 10, 3'b001, 1'b0};
    tbl[6] = '{1'b1, 8'h00, 3'b000, 0,   3'b111, 1'b0, 0,  3'b111, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_idle_outputs("reset");
    chk("reset_readies", 32'({bus.enc_ready, bus.dec_ready}), 0);

    // Both valid from reset: ENC first, then alternating.
    do_job(1'b1, 1'b1, 8'h96, 3'b011, 3, 3'b010, 1'b1, 0, 3'b010, 1'b0, 1'b0);
    do_job(1'b1, 1'b1, 8'h96, 3'b011, 3, 3'b010, 1'b1, 0, 3'b001, 1'b0, 1'b0);
    do_job(1'b1, 1'b1, 8'h0F, 3'b011, 1, 3'b100, 1'b0, 0, 3'b100, 1'b0, 1'b0);

    for (int t = 0; t < 7; t++)
      do_job(tbl[t].is_enc, 1'b0, tbl[t].pay, tbl[t].sym, tbl[t].delay, tbl[t].core_enc,
             tbl[t].core_dec, tbl[t].stall, tbl[t].exp_data, tbl[t].exp_to, 1'b0);

    // Reset during bit 3 of an encode load, then a fresh tie must go to ENC again.
    bus.enc_valid = 1'b1;
    bus.enc_data  = 8'h5A;
    @(negedge clk);
    bus.enc_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midload_bit3", 32'(bus.cdc_bit), 32'((8'h5A >> 3) & 8'd1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_enc = 1'b0;
    chk_idle_outputs("midreset");
    do_job(1'b0, 1'b1, 8'hC3, 3'b110, 4, 3'b011, 1'b1, 1, 3'b011, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      bit         both;
      bit         want;
      bit         k;
      int         dly;
      logic [7:0] pay;
      logic [2:0] sym;
      logic [2:0] ce;
      logic       cd;
      logic [3:0] exp;
      both = 1'($urandom);
      want = 1'($urandom);
      k    = both ? !last_enc : want;
      dly  = int'($urandom_range(0, TIMEOUT + 4));
      pay  = 8'($urandom);
      sym  = 3'($urandom);
      ce   = 3'($urandom);
      cd   = 1'($urandom);
      exp  = model_rsp(k, dly, ce, cd);
      do_job(want, both, pay, sym, dly, ce, cd, int'($urandom_range(0, 3)), exp[2:0], exp[3], 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
